// File: rtl/mem_copy_master.sv
// Word-by-word memory copy engine: READ a source word, WRITE it out, repeat.
// Ports: clock/reset, start/src/dst/len/abort in, memory bus + busy/done/words_done out.
module mem_copy_master #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic [DATA_W-1:0] mem_out,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic len_zero;
  logic last_word;

  assign len_zero  = (len == '0);
  assign last_word = (rem_q == (ADDR_W+1)'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = len_zero ? DONE : READ;
        end
      end
      READ: begin
        state_d = abort ? DONE : WRITE;
      end
      WRITE: begin
        // the write in this cycle always lands; abort only cuts the loop
        state_d = (abort || last_word) ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_address = '0;
    mem_load    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_address = '0;
      end
      READ: begin
        mem_address = src_q;
        busy        = 1'b1;
      end
      WRITE: begin
        mem_address = dst_q;
        mem_load    = 1'b1;
        busy        = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        mem_address = '0;
      end
    endcase
  end

  assign mem_in     = buf_q;
  assign words_done = words_q;

  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    words_d = words_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          words_d = '0;
          if (!len_zero) begin
            src_d = src;
            dst_d = dst;
            rem_d = len;
          end
        end
      end
      READ: begin
        buf_d = mem_out;
      end
      WRITE: begin
        // address counters wrap naturally at ADDR_W bits
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        rem_d   = rem_q - (ADDR_W+1)'(1);
        words_d = words_q + (ADDR_W+1)'(1);
      end
      DONE: begin
        words_d = words_q;
      end
      default: begin
        words_d = words_q;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      buf_q   <= '0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      buf_q   <= buf_d;
    end
  end

endmodule
